// File: rtl/addr_sched_pkg.sv
// Shared types and default parameters for the address burst scheduler.
package addr_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [31:0] STRIDE_DEF = 32'h4;
  localparam int          LEN_W_DEF  = 16;

endpackage

// File: rtl/addr_burst_sched_if.sv
// Command and address-stream bundle between requesters and the burst scheduler.
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high; valid never waits on ready, and payload is
// held stable by the sender while valid is high and ready is low.
interface addr_burst_sched_if #(
  parameter int LEN_W = addr_sched_pkg::LEN_W_DEF
);

  logic             S0_CMD_VALID;
  logic             S1_CMD_VALID;
  logic             S0_CMD_READY;
  logic             S1_CMD_READY;
  logic [31:0]      S0_CMD_BASE;
  logic [31:0]      S1_CMD_BASE;
  logic [LEN_W-1:0] S0_CMD_LEN;
  logic [LEN_W-1:0] S1_CMD_LEN;
  logic [31:0]      M0_AXIS_TDATA;
  logic             M0_AXIS_TVALID;
  logic             M0_AXIS_TREADY;
  logic             M0_AXIS_TLAST;
  logic             M0_AXIS_TUSER;
  logic [1:0]       DONE;
  logic             BUSY;

  // Scheduler side: accepts commands, drives the address stream.
  modport master (
    input  S0_CMD_VALID, S1_CMD_VALID, S0_CMD_BASE, S1_CMD_BASE,
    input  S0_CMD_LEN, S1_CMD_LEN, M0_AXIS_TREADY,
    output S0_CMD_READY, S1_CMD_READY, M0_AXIS_TDATA, M0_AXIS_TVALID,
    output M0_AXIS_TLAST, M0_AXIS_TUSER, DONE, BUSY
  );

  // Environment side: issues commands, consumes the address stream.
  modport slave (
    output S0_CMD_VALID, S1_CMD_VALID, S0_CMD_BASE, S1_CMD_BASE,
    output S0_CMD_LEN, S1_CMD_LEN, M0_AXIS_TREADY,
    input  S0_CMD_READY, S1_CMD_READY, M0_AXIS_TDATA, M0_AXIS_TVALID,
    input  M0_AXIS_TLAST, M0_AXIS_TUSER, DONE, BUSY
  );

endinterface

// File: rtl/addr_burst_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when a burst completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] grant
);

  logic last_served;

  // Resetting to "S1 served last" makes S0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= 1'b1;
    end else if (upd) begin
      last_served <= upd_id;
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_served ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/addr_burst_sched.sv
// Accepts burst commands from two requesters and expands each into a stream
// of LEN+1 addresses spaced by STRIDE, one per accepted beat.
module addr_burst_sched
  import addr_sched_pkg::*;
#(
  parameter logic [31:0] STRIDE = STRIDE_DEF,
  parameter int          LEN_W  = LEN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  addr_burst_sched_if.master  bus,
  output state_t              dbg_state
);

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] rem_q;
  logic             id_q;
  logic [1:0]       done_q;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic [1:0]       cmd_ready;
  logic             accept;
  logic             beat;
  logic             final_beat;

  assign req = {bus.S1_CMD_VALID, bus.S0_CMD_VALID};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .upd    (final_beat),
    .upd_id (id_q),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_ready  = 2'b00;
    accept     = 1'b0;
    beat       = 1'b0;
    final_beat = 1'b0;
    case (state)
      IDLE: begin
        // Ready is gated by rst so nothing looks accepted while held in reset.
        if (!rst && (req != 2'b00)) begin
          cmd_ready = grant;
          accept    = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (bus.M0_AXIS_TREADY) begin
          beat = 1'b1;
          if (rem_q == '0) begin
            final_beat = 1'b1;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The address does not advance on the final beat, so TDATA keeps showing
  // the last emitted address while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= 32'h0;
      rem_q  <= '0;
      id_q   <= 1'b0;
      done_q <= 2'b00;
    end else begin
      done_q <= 2'b00;
      if (accept) begin
        addr_q <= grant[1] ? bus.S1_CMD_BASE : bus.S0_CMD_BASE;
        rem_q  <= grant[1] ? bus.S1_CMD_LEN : bus.S0_CMD_LEN;
        id_q   <= grant[1];
      end else if (beat) begin
        if (final_beat) begin
          done_q <= id_q ? 2'b10 : 2'b01;
        end else begin
          addr_q <= addr_q + STRIDE;
          rem_q  <= rem_q - LEN_ONE;
        end
      end
    end
  end

  assign bus.S0_CMD_READY   = cmd_ready[0];
  assign bus.S1_CMD_READY   = cmd_ready[1];
  assign bus.M0_AXIS_TVALID = (state == BURST);
  assign bus.M0_AXIS_TLAST  = (state == BURST) && (rem_q == '0);
  assign bus.M0_AXIS_TDATA  = addr_q;
  assign bus.M0_AXIS_TUSER  = id_q;
  assign bus.DONE           = done_q;
  assign bus.BUSY           = (state == BURST);
  assign dbg_state          = state;

endmodule

// File: tb/tb_addr_burst_sched.sv
// Directed bench for addr_burst_sched with a transaction-level reference model.
module tb_addr_burst_sched;
  import addr_sched_pkg::*;

  localparam int          LW  = 8;
  localparam logic [31:0] STR = 32'h4;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  addr_burst_sched_if #(.LEN_W(LW)) bus ();

  addr_burst_sched #(.STRIDE(STR), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- observation logs ----------------
  logic [31:0] obs_data[$];
  logic        obs_last[$];
  logic        obs_user[$];
  int          obs_cyc[$];
  logic [1:0]  done_val[$];
  int          done_cyc[$];

  task automatic clear_logs();
    obs_data.delete(); obs_last.delete(); obs_user.delete(); obs_cyc.delete();
    done_val.delete(); done_cyc.delete();
  endtask

  // ---------------- reference model + compare ----------------
  // Expected beats as {id, last, addr}.
  logic [33:0] exp_q[$];
  logic        m_busy = 1'b0;
  logic        m_last = 1'b1;
  logic [1:0]  m_done = 2'b00;
  logic [31:0] m_data = 32'h0;
  logic        m_user = 1'b0;

  always @(negedge clk) begin
    logic [1:0]       v;
    logic [1:0]       g;
    logic [1:0]       dn;
    logic [33:0]      b;
    logic [31:0]      base;
    logic [LW-1:0]    len;
    logic             id;
    if (rst) begin
      chk("rst_tvalid", 64'(bus.M0_AXIS_TVALID), 64'd0);
      chk("rst_tdata",  64'(bus.M0_AXIS_TDATA),  64'd0);
      chk("rst_tuser",  64'(bus.M0_AXIS_TUSER),  64'd0);
      chk("rst_done",   64'(bus.DONE),           64'd0);
      chk("rst_ready",  64'({bus.S1_CMD_READY, bus.S0_CMD_READY}), 64'd0);
      exp_q.delete();
      m_busy = 1'b0; m_last = 1'b1; m_done = 2'b00; m_data = 32'h0; m_user = 1'b0;
    end else begin
      v = {bus.S1_CMD_VALID, bus.S0_CMD_VALID};
      g = 2'b00;
      if (!m_busy && v != 2'b00) begin
        if (v == 2'b11) g = m_last ? 2'b01 : 2'b10;
        else            g = v;
      end
      chk("cmd_ready", 64'({bus.S1_CMD_READY, bus.S0_CMD_READY}), 64'(g));
      chk("tvalid",    64'(bus.M0_AXIS_TVALID), 64'(m_busy));
      chk("busy",      64'(bus.BUSY),           64'(m_busy));
      chk("done",      64'(bus.DONE),           64'(m_done));
      if (m_busy) begin
        if (exp_q.size() == 0) begin
          fail_now("model_beat_underflow");
        end else begin
          b = exp_q[0];
          chk("tdata", 64'(bus.M0_AXIS_TDATA), 64'(b[31:0]));
          chk("tlast", 64'(bus.M0_AXIS_TLAST), 64'(b[32]));
          chk("tuser", 64'(bus.M0_AXIS_TUSER), 64'(b[33]));
        end
      end else begin
        chk("idle_tlast", 64'(bus.M0_AXIS_TLAST), 64'd0);
        chk("idle_tdata", 64'(bus.M0_AXIS_TDATA), 64'(m_data));
        chk("idle_tuser", 64'(bus.M0_AXIS_TUSER), 64'(m_user));
      end
      if (bus.M0_AXIS_TVALID && bus.M0_AXIS_TREADY) begin
        obs_data.push_back(bus.M0_AXIS_TDATA);
        obs_last.push_back(bus.M0_AXIS_TLAST);
        obs_user.push_back(bus.M0_AXIS_TUSER);
        obs_cyc.push_back(cyc);
      end
      if (bus.DONE != 2'b00) begin
        done_val.push_back(bus.DONE);
        done_cyc.push_back(cyc);
      end
      // Advance the model to what the next cycle must look like.
      dn = 2'b00;
      if (g != 2'b00) begin
        id   = g[1];
        base = id ? bus.S1_CMD_BASE : bus.S0_CMD_BASE;
        len  = id ? bus.S1_CMD_LEN : bus.S0_CMD_LEN;
        for (int i = 0; i <= int'(len); i++) begin
          exp_q.push_back({id, (i == int'(len)), base + 32'(i) * STR});
        end
        m_busy = 1'b1;
      end else if (m_busy && bus.M0_AXIS_TREADY && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        m_data = b[31:0];
        m_user = b[33];
        if (b[32]) begin
          m_busy   = 1'b0;
          dn[b[33]] = 1'b1;
          m_last   = b[33];
        end
      end
      m_done = dn;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int s, input logic [31:0] base, input logic [LW-1:0] len);
    logic acc = 1'b0;
    int   n = 0;
    if (s == 0) begin
      bus.S0_CMD_VALID = 1'b1; bus.S0_CMD_BASE = base; bus.S0_CMD_LEN = len;
    end else begin
      bus.S1_CMD_VALID = 1'b1; bus.S1_CMD_BASE = base; bus.S1_CMD_LEN = len;
    end
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = (s == 0) ? bus.S0_CMD_READY : bus.S1_CMD_READY;
      @(posedge clk);
      #1;
      n++;
    end
    if (s == 0) bus.S0_CMD_VALID = 1'b0;
    else        bus.S1_CMD_VALID = 1'b0;
    if (!acc) fail_now("cmd_accept_timeout");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.M0_AXIS_TVALID && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) fail_now("burst_end_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [31:0] e30[4] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
  logic [31:0] e32[3] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
  logic [31:0] e33[4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
  logic [31:0] e35[8] = '{32'h6000, 32'h6004, 32'h7000, 32'h7004,
                          32'h6100, 32'h6104, 32'h7100, 32'h7104};
  logic        u35[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int nl;
    rst = 1'b0;
    bus.S0_CMD_VALID = 1'b0; bus.S1_CMD_VALID = 1'b0;
    bus.S0_CMD_BASE = 32'h0; bus.S1_CMD_BASE = 32'h0;
    bus.S0_CMD_LEN = '0; bus.S1_CMD_LEN = '0;
    bus.M0_AXIS_TREADY = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous single-beat commands right after reset: S0 first.
    clear_logs();
    fork
      send(0, 32'h100, '0);
      send(1, 32'h200, '0);
    join
    wait_idle();
    chk("tie_nbeats", 64'(obs_data.size()), 64'd2);
    chk("tie_data0",  64'(obs_data[0]), 64'h100);
    chk("tie_user0",  64'(obs_user[0]), 64'd0);
    chk("tie_data1",  64'(obs_data[1]), 64'h200);
    chk("tie_user1",  64'(obs_user[1]), 64'd1);
    chk("tie_bubble", 64'(obs_cyc[1] - obs_cyc[0]), 64'd2);
    chk("tie_done0",  64'(done_val[0]), 64'b01);
    chk("tie_done1",  64'(done_val[1]), 64'b10);
    chk("tie_done0_cyc", 64'(done_cyc[0] - obs_cyc[0]), 64'd1);

    // Four-beat burst at full throughput.
    clear_logs();
    send(0, 32'h1000, LW'(3));
    wait_idle();
    chk("b4_nbeats", 64'(obs_data.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk("b4_data", 64'(obs_data[k]), 64'(e30[k]));
      chk("b4_last", 64'(obs_last[k]), 64'(k == 3));
      chk("b4_cyc",  64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
    end
    chk("b4_done",     64'(done_val[0]), 64'b01);
    chk("b4_done_cyc", 64'(done_cyc[0] - obs_cyc[3]), 64'd1);

    // Address wrap at the top of the 32-bit space.
    clear_logs();
    send(1, 32'hFFFFFFF8, LW'(2));
    wait_idle();
    chk("wrap_nbeats", 64'(obs_data.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("wrap_data", 64'(obs_data[k]), 64'(e32[k]));
      chk("wrap_last", 64'(obs_last[k]), 64'(k == 2));
    end

    // Backpressure 1,0,0,1 on the first four cycles of the burst.
    clear_logs();
    send(0, 32'h2000, LW'(3));
    @(posedge clk); #1 bus.M0_AXIS_TREADY = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus.M0_AXIS_TREADY = 1'b1;
    wait_idle();
    chk("bp_nbeats", 64'(obs_data.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("bp_data", 64'(obs_data[k]), 64'(e33[k]));
    chk("bp_gap01", 64'(obs_cyc[1] - obs_cyc[0]), 64'd3);
    chk("bp_gap12", 64'(obs_cyc[2] - obs_cyc[1]), 64'd1);

    // All-ones length gives 2^LW beats.
    clear_logs();
    send(0, 32'h5000, {LW{1'b1}});
    wait_idle();
    nl = 0;
    foreach (obs_last[k]) if (obs_last[k]) nl++;
    chk("max_nbeats", 64'(obs_data.size()), 64'd256);
    chk("max_lastdata", 64'(obs_data[255]), 64'h53FC);
    chk("max_nlast", 64'(nl), 64'd1);
    chk("max_lastflag", 64'(obs_last[255]), 64'd1);

    // Reset in the middle of an eight-beat burst.
    clear_logs();
    send(0, 32'h3000, LW'(7));
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("mrst_tvalid", 64'(bus.M0_AXIS_TVALID), 64'd0);
    chk("mrst_tlast",  64'(bus.M0_AXIS_TLAST),  64'd0);
    chk("mrst_busy",   64'(bus.BUSY),           64'd0);
    chk("mrst_tdata",  64'(bus.M0_AXIS_TDATA),  64'd0);
    chk("mrst_state",  64'(dbg_state),          64'(IDLE));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_nbeats", 64'(obs_data.size()), 64'd2);
    chk("mrst_nodone", 64'(done_val.size()), 64'd0);
    clear_logs();
    send(1, 32'h4000, LW'(1));
    wait_idle();
    chk("mrst_restart_data", 64'(obs_data[0]), 64'h4000);
    chk("mrst_restart_user", 64'(obs_user[0]), 64'd1);
    chk("mrst_restart_n",    64'(obs_data.size()), 64'd2);

    // S1 keeps requesting while S0 issues two commands: strict alternation.
    clear_logs();
    fork
      begin send(0, 32'h6000, LW'(1)); send(0, 32'h6100, LW'(1)); end
      begin send(1, 32'h7000, LW'(1)); send(1, 32'h7100, LW'(1)); end
    join
    wait_idle();
    chk("rr_nbeats", 64'(obs_data.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      chk("rr_data", 64'(obs_data[k]), 64'(e35[k]));
      chk("rr_user", 64'(obs_user[k]), 64'(u35[k]));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_burst_sched.md
ADDR_BURST_SCHED -- requirements
Module: addr_burst_sched

Interface
REQ-001 SHALL have parameter STRIDE, default 32'h4, address increment per beat.
REQ-002 SHALL have parameter LEN_W, default 16, width of burst length field.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports S0_CMD_VALID / S1_CMD_VALID  input  1 each  requester command valid.
REQ-006 SHALL have ports S0_CMD_READY / S1_CMD_READY  output  1 each  command accepted.
REQ-007 SHALL have ports S0_CMD_BASE / S1_CMD_BASE  input  32 each  burst start address.
REQ-008 SHALL have ports S0_CMD_LEN / S1_CMD_LEN  input  LEN_W each  beats minus one.
REQ-009 SHALL have ports M0_AXIS_TDATA  output  32, M0_AXIS_TVALID  output  1, M0_AXIS_TREADY  input  1, M0_AXIS_TLAST  output  1: address stream.
REQ-010 SHALL have port M0_AXIS_TUSER  output  1  source id of current beat (0=S0, 1=S1).
REQ-011 SHALL have port DONE  output  2  one-cycle completion pulse per requester.
REQ-012 SHALL have port BUSY  output  1  high while state is BURST.

Function
REQ-013 SHALL implement two states, IDLE and BURST.
REQ-014 In IDLE with any CMD_VALID high, SHALL assert CMD_READY combinationally for exactly the granted requester, latch its BASE, LEN and id, and enter BURST next cycle.
REQ-015 Grant SHALL be round-robin: a single requester always wins; with both valid, the requester not most recently served wins; after reset S0 wins the first tie.
REQ-016 CMD_READY SHALL be low in BURST and for the non-granted requester.
REQ-017 First beat SHALL present TVALID=1, TDATA=BASE on the cycle after command acceptance (latency 1).
REQ-018 In BURST, TVALID SHALL be 1; TDATA, TLAST, TUSER SHALL hold stable while TREADY is low.
REQ-019 On each TVALID&TREADY, address SHALL advance by STRIDE modulo 2^32 (0xFFFFFFFC+4 -> 0x00000000) and remaining count SHALL decrement.
REQ-020 A burst SHALL emit exactly LEN+1 beats; TLAST SHALL be 1 on the final beat only; LEN=0 yields one beat with TLAST=1; LEN=all-ones yields 2^LEN_W beats.
REQ-021 On the final handshake, SHALL return to IDLE and pulse DONE[id] high for the following cycle only.
REQ-022 Earliest next command acceptance SHALL be the cycle after the final handshake (one idle bubble between bursts).
REQ-023 In IDLE, TVALID, TLAST SHALL be 0; TDATA and TUSER hold last values.
REQ-024 CMD_VALID changes during BURST SHALL have no effect on the active burst.

Reset
REQ-025 Asserting rst SHALL immediately force state IDLE, TVALID=0, TLAST=0, TDATA=0, TUSER=0, DONE=0, BUSY=0, CMD_READY=0, round-robin pointer to favour S0.
REQ-026 Reset mid-burst SHALL abandon the burst with no DONE pulse; remaining beats are lost.
REQ-027 First command SHALL be accepted no earlier than the first clock edge after rst deasserts.

Structure
REQ-028 Package addr_sched_pkg SHALL hold the state enum, STRIDE and LEN_W defaults.
REQ-029 Round-robin grant SHALL be a sub-module rr_arb2 (2 requests, grant, last-served update on burst completion).

Verification
REQ-030 S0 only, BASE=0x1000, LEN=3, TREADY=1 -> TDATA 0x1000,0x1004,0x1008,0x100C on consecutive cycles, TLAST on 0x100C, DONE[0] next cycle.
REQ-031 S0 and S1 valid together after reset, LEN=0 each -> S0 beat first, S1 beat after one bubble, TUSER 0 then 1, DONE[0] then DONE[1].
REQ-032 BASE=0xFFFFFFF8, LEN=2 -> TDATA 0xFFFFFFF8,0xFFFFFFFC,0x00000000, TLAST on third.
REQ-033 TREADY toggled 1,0,0,1 during LEN=3 burst -> TDATA/TLAST held during low cycles, four beats total, no skipped address.
REQ-034 rst asserted after second beat of LEN=7 burst -> TVALID low same cycle, no DONE, next command restarts at its BASE.
REQ-035 S1 held valid continuously, S0 issues two commands -> grants alternate S0,S1,S0; S1 never starved.
